seq_scan_arbiter: RTL and testbench

Round-robin scheduler that shares one bit-serial "0101" sequence detector between `NREQ` requesters. Each requester hands over a `WIDTH`-bit word. The arbiter grants one requester at a time, clears the detector, and shifts the word MSB-first into it at one bit per clock. When the word is finished it reports the number of matches and the requester id. It sits between parallel producers and the serial pattern-detection datapath.

---
 rtl/seq_scan_pkg.sv | 24 ++
 rtl/det0101_core.sv | 53 +++++
 rtl/seq_scan_arbiter.sv | 126 ++++++++++++
 tb/tb_seq_scan_arbiter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/seq_scan_pkg.sv
// Purpose: shared encodings for the sequence-scan arbiter and its 0101 detector.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package seq_scan_pkg;

    // Detector state: how much of "0101" has been seen so far.
    typedef enum logic [1:0] {
        DET_IDLE = 2'd0,
        DET_0    = 2'd1,
        DET_01   = 2'd2,
        DET_010  = 2'd3
    } det_state_t;

    // Controller state of the arbiter.
    typedef enum logic [1:0] {
        CTL_IDLE   = 2'd0,
        CTL_SHIFT  = 2'd1,
        CTL_REPORT = 2'd2
    } ctl_state_t;

    // Width of requester ids (supports up to 8 requesters).
    localparam int IDW = 3;

endpackage

// File: rtl/det0101_core.sv
// Purpose: bit-serial "0101" detector FSM with a Mealy match strobe.
// Latency: match is combinational on the current bit; state updates next edge.
// Backpressure: none; consumes In only when en is high, clr wins over en.
// Optional macro SEQ_OVERLAP_EN: after a match, resume from "01" to count overlaps.
// Ports: Clk, rst (async active-low), clr (force state 0), en (consume In),
//        In (serial bit), match (pattern completes on this bit), State (2-bit).
module det0101_core
    import seq_scan_pkg::*;
(
    input  logic       Clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       In,
    output logic       match,
    output logic [1:0] State
);

    det_state_t st;
    det_state_t st_nxt;

    always_comb begin
        st_nxt = st;
        unique case (st)
            DET_IDLE: st_nxt = In ? DET_IDLE : DET_0;
            DET_0:    st_nxt = In ? DET_01   : DET_0;
            DET_01:   st_nxt = In ? DET_IDLE : DET_010;
            DET_010: begin
`ifdef SEQ_OVERLAP_EN
                // Trailing "01" of a match is the head of the next pattern.
                st_nxt = In ? DET_01 : DET_0;
`else
                st_nxt = In ? DET_IDLE : DET_0;
`endif
            end
            default:  st_nxt = DET_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            st <= DET_IDLE;
        end else if (clr) begin
            st <= DET_IDLE;
        end else if (en) begin
            st <= st_nxt;
        end
    end

    assign match = en && (st == DET_010) && In;
    assign State = st;

endmodule

// File: rtl/seq_scan_arbiter.sv
// Purpose: round-robin share of one serial 0101 detector among NREQ word producers.
// Latency: ack in cycle T, bits T+1..T+WIDTH, done at T+WIDTH+1; one word per WIDTH+2 cycles.
// Backpressure: req is level and only sampled in IDLE; ack pulses in the capture cycle.
// Optional macro SEQ_OVERLAP_EN (passed to det0101_core): overlapping match counting.
// Ports: Clk, rst (async active-low), req[NREQ], data[NREQ*WIDTH] (word i at i*WIDTH),
//        ack[NREQ], busy, ser_bit, det_state[2], done, done_id[3], done_cnt[CNTW].
module seq_scan_arbiter
    import seq_scan_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int CNTW  = 4
) (
    input  logic                    Clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   data,
    output logic [NREQ-1:0]         ack,
    output logic                    busy,
    output logic                    ser_bit,
    output logic [1:0]              det_state,
    output logic                    done,
    output logic [IDW-1:0]          done_id,
    output logic [CNTW-1:0]         done_cnt
);

    localparam int BW = $clog2(WIDTH);

    ctl_state_t       ctl;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   gid;
    logic [WIDTH-1:0] shreg;
    logic [BW-1:0]    bitcnt;
    logic [CNTW-1:0]  mcnt;
    logic [CNTW-1:0]  mcnt_nxt;

    logic             gnt_vld;
    logic [IDW-1:0]   gnt_idx;
    logic             capture;
    logic             last_bit;
    logic             det_en;
    logic             det_clr;
    logic             det_match;

    // Search ptr+1, ptr+2, ... with wrap; walking k downward lets the
    // nearest requester overwrite any farther one.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = NREQ; k >= 1; k--) begin
            if (req[(int'(ptr) + k) % NREQ]) begin
                gnt_vld = 1'b1;
                gnt_idx = IDW'((int'(ptr) + k) % NREQ);
            end
        end
    end

    // Capture is decided in the IDLE cycle itself so ack and the data sample
    // share one cycle; gating with rst keeps ack/busy low while in reset.
    assign capture  = rst && (ctl == CTL_IDLE) && gnt_vld;
    assign ack      = capture ? (NREQ'(1) << gnt_idx) : '0;
    assign busy     = capture || (ctl != CTL_IDLE);
    assign ser_bit  = (ctl == CTL_SHIFT) && shreg[WIDTH-1];
    assign last_bit = (ctl == CTL_SHIFT) && (bitcnt == BW'(WIDTH - 1));

    // Detector runs only during SHIFT and is parked at state 0 on the final
    // bit so it reads 0 throughout REPORT and IDLE.
    assign det_en  = (ctl == CTL_SHIFT);
    assign det_clr = (ctl != CTL_SHIFT) || last_bit;

    det0101_core u_det (
        .Clk   (Clk),
        .rst   (rst),
        .clr   (det_clr),
        .en    (det_en),
        .In    (ser_bit),
        .match (det_match),
        .State (det_state)
    );

    // Saturating match count.
    assign mcnt_nxt = (det_match && (mcnt != {CNTW{1'b1}})) ? mcnt + 1'b1 : mcnt;

    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            ctl      <= CTL_IDLE;
            ptr      <= IDW'(NREQ - 1);
            gid      <= '0;
            shreg    <= '0;
            bitcnt   <= '0;
            mcnt     <= '0;
            done     <= 1'b0;
            done_id  <= '0;
            done_cnt <= '0;
        end else begin
            done <= 1'b0;
            unique case (ctl)
                CTL_IDLE: begin
                    if (capture) begin
                        shreg  <= data[gnt_idx*WIDTH +: WIDTH];
                        gid    <= gnt_idx;
                        ptr    <= gnt_idx;
                        bitcnt <= '0;
                        mcnt   <= '0;
                        ctl    <= CTL_SHIFT;
                    end
                end
                CTL_SHIFT: begin
                    shreg  <= shreg << 1;
                    bitcnt <= bitcnt + 1'b1;
                    mcnt   <= mcnt_nxt;
                    if (last_bit) begin
                        // Report includes a match landing on the final bit.
                        done     <= 1'b1;
                        done_id  <= gid;
                        done_cnt <= mcnt_nxt;
                        ctl      <= CTL_REPORT;
                    end
                end
                CTL_REPORT: ctl <= CTL_IDLE;
                default:    ctl <= CTL_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_scan_arbiter.sv
// Purpose: directed self-checking bench for seq_scan_arbiter (NREQ=4, WIDTH=8, CNTW=4).
// Latency: inputs change 2 time units after a rising edge; outputs sampled 1 unit later.
// Backpressure: n/a.
module tb_seq_scan_arbiter;

    logic        Clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  ack;
    logic        busy;
    logic        ser_bit;
    logic [1:0]  det_state;
    logic        done;
    logic [2:0]  done_id;
    logic [3:0]  done_cnt;

    int checks = 0;
    int failures = 0;

`ifdef SEQ_OVERLAP_EN
    localparam int CNT55 = 3;
`else
    localparam int CNT55 = 2;
`endif

    seq_scan_arbiter #(.NREQ(4), .WIDTH(8), .CNTW(4)) dut (
        .Clk       (Clk),
        .rst       (rst),
        .req       (req),
        .data      (data),
        .ack       (ack),
        .busy      (busy),
        .ser_bit   (ser_bit),
        .det_state (det_state),
        .done      (done),
        .done_id   (done_id),
        .done_cnt  (done_cnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #2;
    endtask

    // One word from requester id, starting in an IDLE cycle; ends in IDLE.
    task automatic run_word(input int id, input logic [7:0] w, input int exp_cnt,
                            input bit zero_chk, input bit noise);
        req = '0;
        req[id] = 1'b1;
        data[id*8 +: 8] = w;
        #1;
        chk("ack_capture", {28'd0, ack}, 32'(1 << id));
        chk("busy_capture", {31'd0, busy}, 32'd1);
        #1;
        step();
        req  = '0;
        data = 32'hDEAD_BEEF;   // data only needs to hold in the capture cycle
        for (int i = 1; i <= 8; i++) begin
            #1;
            chk("ser_bit", {31'd0, ser_bit}, {31'd0, w[8-i]});
            chk("busy_shift", {31'd0, busy}, 32'd1);
            if (zero_chk) chk("det_state_zero", {30'd0, det_state}, (i == 1) ? 32'd0 : 32'd1);
            if (noise && i == 3) begin
                req = 4'b1111;
                #1;
                chk("ack_during_shift", {28'd0, ack}, 32'd0);
            end
            if (noise && i == 5) req = '0;
            step();
        end
        #1;
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("done_id", {29'd0, done_id}, 32'(id));
        chk("done_cnt", {28'd0, done_cnt}, 32'(exp_cnt));
        chk("det_state_report", {30'd0, det_state}, 32'd0);
        step();
        #1;
        chk("done_cleared", {31'd0, done}, 32'd0);
        chk("busy_idle", {31'd0, busy}, 32'd0);
        #1;
    endtask

    initial begin
        rst  = 1'b0;
        req  = 4'b1111;
        data = '0;
        #1;
        chk("reset_ack", {28'd0, ack}, 32'd0);
        chk("reset_outs", {20'd0, busy, ser_bit, det_state, done, done_id, done_cnt}, 32'd0);
        repeat (2) @(posedge Clk);
        #2;
        req = '0;
        rst = 1'b1;
        step();

        // 0x35 = 0011_0101: one match; req noise during SHIFT ignored.
        run_word(0, 8'h35, 1, 1'b0, 1'b1);
        // 0x55 = 0101_0101: two disjoint matches (three when overlapping).
        run_word(1, 8'h55, CNT55, 1'b0, 1'b0);
        // 0x00: no match, detector sits in "0" from the second bit on.
        run_word(3, 8'h00, 0, 1'b1, 1'b0);

        // Round robin with req[0] and req[2] held: pointer is 3 here.
        data = {8'h00, 8'h00, 8'h00, 8'h35};
        req  = 4'b0101;
        for (int g = 0; g < 4; g++) begin
            int exp_id;
            exp_id = (g % 2 == 0) ? 0 : 2;
            #1;
            chk("rr_ack", {28'd0, ack}, 32'(1 << exp_id));
            #1;
            for (int k = 1; k <= 9; k++) begin
                step();
                #1;
                if (k < 9) chk("rr_no_ack", {28'd0, ack}, 32'd0);
                #1;
            end
            #1;
            chk("rr_done", {31'd0, done}, 32'd1);
            chk("rr_done_id", {29'd0, done_id}, 32'(exp_id));
            chk("rr_done_cnt", {28'd0, done_cnt}, (exp_id == 0) ? 32'd1 : 32'd0);
            #1;
            step();
        end
        req = '0;
        step();

        // Split pattern across words: "0000_0001" then "0100_0000".
        run_word(1, 8'h01, 0, 1'b0, 1'b0);
        run_word(1, 8'h40, 0, 1'b0, 1'b0);

        // Reset mid-word: capture at T, reset at T+4.
        req  = 4'b0010;
        data = {8'h00, 8'h00, 8'h55, 8'h00};
        #1;
        chk("mid_ack", {28'd0, ack}, 32'h2);
        #1;
        step();
        req = '0;
        repeat (3) step();
        rst = 1'b0;
        #1;
        chk("mid_rst_ack", {28'd0, ack}, 32'd0);
        chk("mid_rst_outs", {20'd0, busy, ser_bit, det_state, done, done_id, done_cnt}, 32'd0);
        #1;
        for (int k = 0; k < 3; k++) begin
            step();
            #1;
            chk("mid_rst_no_done", {31'd0, done}, 32'd0);
            #1;
        end
        rst = 1'b1;
        step();
        #1;
        chk("post_rst_no_done", {31'd0, done}, 32'd0);
        #1;
        // Pointer back at 3: requesters 1 and 2 both ask, 1 wins.
        req  = 4'b0110;
        data = {8'h00, 8'hA5, 8'h55, 8'h00};
        #1;
        chk("ptr_reset_ack", {28'd0, ack}, 32'h2);
        #1;
        step();
        req = '0;
        repeat (8) step();
        #1;
        chk("ptr_reset_done_id", {29'd0, done_id}, 32'd1);
        chk("ptr_reset_done_cnt", {28'd0, done_cnt}, 32'(CNT55));
        #1;
        step();
        // 0xA5 = 1010_0101: single match on the final bit.
        run_word(2, 8'hA5, 1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
